cpu_sram_responder: RTL and testbench



---
 rtl/cpu_sram_responder.sv | 142 ++++++++++++++
 tb/tb_cpu_sram_responder.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sram_responder.sv
// Memory-side responder for a single-cycle CPU: shared word RAM behind the
// instruction and data ports, plus a small MMIO window (LED, NUM, TIMER, HALT, ERR).
module cpu_sram_responder #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter logic [31:0] RAM_BASE   = 32'h1c000000,
  parameter logic [31:0] MMIO_BASE  = 32'hbfaf0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_we,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  output logic [31:0] num,
  output logic        halted,
  output logic        err
);

  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [11:0] OFF_LED   = 12'h000;
  localparam logic [11:0] OFF_NUM   = 12'h004;
  localparam logic [11:0] OFF_TIMER = 12'h008;
  localparam logic [11:0] OFF_HALT  = 12'h00c;
  localparam logic [11:0] OFF_ERR   = 12'h010;

  logic [31:0]           mem [DEPTH];
  logic [31:0]           timer;
  logic [31:0]           i_off;
  logic [31:0]           d_off;
  logic                  i_hit;
  logic                  d_hit;
  logic                  d_mmio;
  logic                  d_aligned;
  logic [ADDR_WIDTH-1:0] i_idx;
  logic [ADDR_WIDTH-1:0] d_idx;
  logic                  wr_en;
  logic                  ram_we;
  logic                  led_we;
  logic                  num_we;
  logic                  timer_we;
  logic                  halt_we;
  logic                  err_set;
  logic                  err_clr;
  logic                  unused_ok;

  // Offset-from-base with zero upper bits means the address falls inside the RAM
  assign i_off     = inst_sram_addr - RAM_BASE;
  assign d_off     = data_sram_addr - RAM_BASE;
  assign i_hit     = (i_off[31:ADDR_WIDTH+2] == '0);
  assign d_hit     = (d_off[31:ADDR_WIDTH+2] == '0);
  assign i_idx     = i_off[ADDR_WIDTH+1:2];
  assign d_idx     = d_off[ADDR_WIDTH+1:2];
  assign d_mmio    = (data_sram_addr[31:12] == MMIO_BASE[31:12]);
  assign d_aligned = (data_sram_addr[1:0] == 2'b00);
  assign unused_ok = ^{inst_sram_wdata, i_off[1:0], d_off[1:0]};

  // Out-of-range fetches return zero: PC sits below RAM while in reset
  assign inst_sram_rdata = i_hit ? mem[i_idx] : '0;

  always_comb begin
    data_sram_rdata = '0;
    if (d_hit) begin
      data_sram_rdata = mem[d_idx];
    end else if (d_mmio) begin
      case (data_sram_addr[11:0])
        OFF_LED:   data_sram_rdata = {16'b0, led};
        OFF_NUM:   data_sram_rdata = num;
        OFF_TIMER: data_sram_rdata = timer;
        OFF_HALT:  data_sram_rdata = {31'b0, halted};
        OFF_ERR:   data_sram_rdata = {31'b0, err};
        default:   data_sram_rdata = '0;
      endcase
    end
  end

  always_comb begin
    ram_we   = 1'b0;
    led_we   = 1'b0;
    num_we   = 1'b0;
    timer_we = 1'b0;
    halt_we  = 1'b0;
    err_clr  = 1'b0;
    err_set  = resetn && inst_sram_we;
    // resetn folded in so the RAM (which has no reset) ignores writes during reset
    wr_en    = resetn && data_sram_we && !halted;
    if (wr_en) begin
      if (!d_aligned) begin
        err_set = 1'b1;
      end else if (d_hit) begin
        ram_we = 1'b1;
      end else if (d_mmio) begin
        case (data_sram_addr[11:0])
          OFF_LED:   led_we   = 1'b1;
          OFF_NUM:   num_we   = 1'b1;
          OFF_TIMER: timer_we = 1'b1;
          OFF_HALT:  halt_we  = 1'b1;
          OFF_ERR:   err_clr  = data_sram_wdata[0];
          default:   err_set  = 1'b1;
        endcase
      end else begin
        err_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[d_idx] <= data_sram_wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led    <= '0;
      num    <= '0;
      timer  <= '0;
      halted <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (led_we) led <= data_sram_wdata[15:0];
      if (num_we) num <= data_sram_wdata;
      if (timer_we) begin
        timer <= data_sram_wdata;
      end else if (!halted) begin
        timer <= timer + 32'd1;
      end
      if (halt_we) halted <= 1'b1;
      // A same-cycle error wins over a software clear
      if (err_set) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_sram_responder.sv
// Randomized bench for cpu_sram_responder against a behavioural memory-map model.
module tb_cpu_sram_responder;

  localparam logic [31:0] RAM_BASE  = 32'h1c000000;
  localparam logic [31:0] RAM_END   = 32'h1c010000;
  localparam logic [31:0] MMIO_BASE = 32'hbfaf0000;
  localparam logic [19:0] MMIO_PAGE = 20'hbfaf0;
  localparam int          NIDX      = 17;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [15:0] led;
  logic [31:0] num;
  logic        halted;
  logic        err;

  cpu_sram_responder dut (
    .clk             (clk),
    .resetn          (resetn),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .led             (led),
    .num             (num),
    .halted          (halted),
    .err             (err)
  );

  // scoreboard counters
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // reference model: sparse word memory plus register variables
  logic [31:0] m_mem [int];
  logic [15:0] m_led;
  logic [31:0] m_num;
  logic [31:0] m_timer;
  bit          m_halted;
  bit          m_err;
  int          idx_tab [NIDX];

  function automatic bit ram_hit(input logic [31:0] a);
    return (a >= RAM_BASE) && (a < RAM_END);
  endfunction

  function automatic int ram_idx(input logic [31:0] a);
    return int'((a - RAM_BASE) / 4);
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return a[31:12] == MMIO_PAGE;
  endfunction

  function automatic bit known(input logic [31:0] a);
    return !ram_hit(a) || m_mem.exists(ram_idx(a));
  endfunction

  function automatic logic [31:0] mdl_inst(input logic [31:0] a);
    return ram_hit(a) ? m_mem[ram_idx(a)] : 32'h0;
  endfunction

  function automatic logic [31:0] mdl_data(input logic [31:0] a);
    if (ram_hit(a)) return m_mem[ram_idx(a)];
    if (is_mmio(a)) begin
      case (a - MMIO_BASE)
        32'h00:  return {16'h0, m_led};
        32'h04:  return m_num;
        32'h08:  return m_timer;
        32'h0c:  return {31'h0, m_halted};
        32'h10:  return {31'h0, m_err};
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  function automatic void model_reset();
    m_led    = '0;
    m_num    = '0;
    m_timer  = '0;
    m_halted = 1'b0;
    m_err    = 1'b0;
  endfunction

  // One rising edge out of reset: all effects computed from pre-edge state
  function automatic void model_edge();
    logic [31:0] a         = data_sram_addr;
    logic [31:0] nxt_timer = m_halted ? m_timer : m_timer + 32'd1;
    bit          nxt_halt  = m_halted;
    bit          set_e     = inst_sram_we;
    bit          clr_e     = 1'b0;
    if (data_sram_we && !m_halted) begin
      if (a % 4 != 0) set_e = 1'b1;
      else if (ram_hit(a)) m_mem[ram_idx(a)] = data_sram_wdata;
      else if (is_mmio(a)) begin
        case (a - MMIO_BASE)
          32'h00:  m_led = data_sram_wdata[15:0];
          32'h04:  m_num = data_sram_wdata;
          32'h08:  nxt_timer = data_sram_wdata;
          32'h0c:  nxt_halt = 1'b1;
          32'h10:  clr_e = data_sram_wdata[0];
          default: set_e = 1'b1;
        endcase
      end else set_e = 1'b1;
    end
    m_timer  = nxt_timer;
    m_halted = nxt_halt;
    if (set_e) m_err = 1'b1;
    else if (clr_e) m_err = 1'b0;
  endfunction

  // driver: called just after a negedge with inputs already set; returns at next negedge
  task automatic do_cycle();
    #2;
    if (known(inst_sram_addr)) check("inst_rdata", inst_sram_rdata, mdl_inst(inst_sram_addr));
    if (known(data_sram_addr)) check("data_rdata", data_sram_rdata, mdl_data(data_sram_addr));
    @(posedge clk);
    if (resetn) model_edge();
    @(negedge clk);
    check("led", {16'h0, led}, {16'h0, m_led});
    check("num", num, m_num);
    check("halted", {31'h0, halted}, {31'h0, m_halted});
    check("err", {31'h0, err}, {31'h0, m_err});
  endtask

  task automatic idle();
    inst_sram_we = 1'b0;
    data_sram_we = 1'b0;
  endtask

  function automatic logic [31:0] rand_data_addr();
    int sel = $urandom_range(0, 9);
    int k   = idx_tab[$urandom_range(0, NIDX-1)];
    logic [31:0] offs [5] = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h14};
    if (sel < 5) return RAM_BASE + 32'(4 * k);
    if (sel == 5) return RAM_BASE + 32'(4 * k) + 32'($urandom_range(1, 3));
    if (sel < 8) return MMIO_BASE + offs[$urandom_range(0, 4)];
    if (sel == 8) return 32'h00001000 + 32'(4 * $urandom_range(0, 3));
    return RAM_END;
  endfunction

  initial begin
    logic [31:0] old_w;
    logic [31:0] t_hold;
    int          w_idx;

    for (int i = 0; i < 16; i++) idx_tab[i] = i;
    idx_tab[16] = (1 << 14) - 1;
    resetn          = 1'b1;
    inst_sram_we    = 1'b0;
    inst_sram_addr  = 32'h1bfffffc;
    inst_sram_wdata = '0;
    data_sram_we    = 1'b0;
    data_sram_addr  = '0;
    data_sram_wdata = '0;
    model_reset();
    #1 resetn = 1'b0;
    @(negedge clk);
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_num", num, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    repeat (2) do_cycle();

    // release and count exactly ten edges
    resetn         = 1'b1;
    data_sram_addr = MMIO_BASE + 32'h8;
    repeat (10) do_cycle();
    #1 check("timer_after_reset", data_sram_rdata, 32'd10);

    // preload the tracked RAM words, including the last word of RAM
    for (int i = 0; i < NIDX; i++) begin
      data_sram_we    = 1'b1;
      data_sram_addr  = RAM_BASE + 32'(4 * idx_tab[i]);
      data_sram_wdata = $urandom;
      do_cycle();
    end
    idle();

    // write and fetch the same word in one cycle
    old_w           = m_mem[4];
    inst_sram_addr  = 32'h1c000010;
    data_sram_addr  = 32'h1c000010;
    data_sram_wdata = 32'hdeadbeef;
    data_sram_we    = 1'b1;
    #1 check("inst_old_word", inst_sram_rdata, old_w);
    do_cycle();
    idle();
    #1 check("inst_new_word", inst_sram_rdata, 32'hdeadbeef);
    check("data_new_word", data_sram_rdata, 32'hdeadbeef);
    do_cycle();

    // out-of-range fetch, illegal data write, software error clear
    inst_sram_addr = 32'h1bfffffc;
    #1 check("inst_oob_zero", inst_sram_rdata, 32'h0);
    check("err_clear_start", {31'h0, err}, 32'h0);
    data_sram_addr  = 32'h00001000;
    data_sram_wdata = 32'h11111111;
    data_sram_we    = 1'b1;
    do_cycle();
    check("err_bad_write", {31'h0, err}, 32'h1);
    data_sram_addr  = MMIO_BASE + 32'h10;
    data_sram_wdata = 32'h1;
    do_cycle();
    check("err_cleared", {31'h0, err}, 32'h0);
    idle();

    // timer wrap
    data_sram_addr  = MMIO_BASE + 32'h8;
    data_sram_wdata = 32'hfffffffe;
    data_sram_we    = 1'b1;
    do_cycle();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1 check("timer_wrap", data_sram_rdata, 32'hfffffffe + 32'(i));
      do_cycle();
    end

    // randomized traffic (no HALT writes)
    for (int n = 0; n < 400; n++) begin
      data_sram_we    = ($urandom_range(0, 2) != 0);
      data_sram_addr  = rand_data_addr();
      data_sram_wdata = $urandom;
      inst_sram_we    = ($urandom_range(0, 49) == 0);
      inst_sram_addr  = ($urandom_range(0, 4) == 0) ? 32'h1bfffffc
                        : RAM_BASE + 32'(4 * idx_tab[$urandom_range(0, NIDX-1)]);
      do_cycle();
    end
    idle();

    // reset asserted in the middle of a RAM write
    data_sram_addr  = MMIO_BASE;
    data_sram_wdata = 32'h00005a5a;
    data_sram_we    = 1'b1;
    do_cycle();
    w_idx           = idx_tab[2];
    old_w           = m_mem[w_idx];
    data_sram_addr  = RAM_BASE + 32'(4 * w_idx);
    data_sram_wdata = ~old_w;
    #2 resetn = 1'b0;
    #1;
    check("async_led", {16'h0, led}, 32'h0);
    check("async_num", num, 32'h0);
    check("async_err", {31'h0, err}, 32'h0);
    check("async_halted", {31'h0, halted}, 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    data_sram_we = 1'b0;
    resetn       = 1'b1;
    #1 check("no_inflight_write", data_sram_rdata, old_w);
    do_cycle();

    // LED write, halt, then writes ignored and timer frozen
    data_sram_addr  = MMIO_BASE;
    data_sram_wdata = 32'h1234abcd;
    data_sram_we    = 1'b1;
    do_cycle();
    idle();
    check("led_low16", {16'h0, led}, 32'h0000abcd);
    #1 check("led_read", data_sram_rdata, 32'h0000abcd);
    data_sram_addr = MMIO_BASE + 32'hc;
    data_sram_we   = 1'b1;
    do_cycle();
    check("halt_set", {31'h0, halted}, 32'h1);
    data_sram_addr  = MMIO_BASE;
    data_sram_wdata = 32'h0000ffff;
    do_cycle();
    check("led_after_halt", {16'h0, led}, 32'h0000abcd);
    idle();
    data_sram_addr = MMIO_BASE + 32'h8;
    t_hold         = m_timer;
    for (int i = 0; i < 5; i++) begin
      #1 check("timer_frozen", data_sram_rdata, t_hold);
      do_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
